// File: rtl/wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue_pkg
// Purpose  : Shared widths and the queued register-write entry type.
// Revision : 1.0 - initial release
// ============================================================================
package wb_queue_pkg;

  localparam int WORD_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_SEL_W-1:0] regsel;
    logic [WORD_W-1:0]    data;
  } wbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue_if
// Purpose  : Writeback handshake, register-file write port and read mirror.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_queue_if #(
  parameter int DEPTH = 4
);
  import wb_queue_pkg::*;

  logic                       in_valid;
  logic [REG_SEL_W-1:0]       in_regsel;
  logic [WORD_W-1:0]          in_data;
  logic                       in_ready;
  logic                       drain_en;
  logic [REG_SEL_W-1:0]       writeregsel;
  logic [WORD_W-1:0]          writedata;
  logic                       write;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [REG_SEL_W-1:0]       read1regsel;
  logic [REG_SEL_W-1:0]       read2regsel;
  logic                       fwd1_hit;
  logic                       fwd2_hit;
  logic [WORD_W-1:0]          fwd1_data;
  logic [WORD_W-1:0]          fwd2_data;

  modport master (
    output in_valid, in_regsel, in_data, drain_en, read1regsel, read2regsel,
    input  in_ready, writeregsel, writedata, write, count,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  modport slave (
    input  in_valid, in_regsel, in_data, drain_en, read1regsel, read2regsel,
    output in_ready, writeregsel, writedata, write, count,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

endinterface
`default_nettype wire

// File: rtl/wb_queue_match.sv
`default_nettype none
// ============================================================================
// Module   : wbq_match
// Purpose  : Finds the youngest queued write targeting one read select.
// Revision : 1.0 - initial release
// ============================================================================
module wbq_match import wb_queue_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  wbq_entry_t                 entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [REG_SEL_W-1:0]       rd_sel,
  output logic                       hit,
  output logic [WORD_W-1:0]          data
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [c_ptr_w-1:0] w_idx;

  // Walk oldest to youngest so the last match seen is the newest value.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head + c_ptr_w'(i);
      if (valid[w_idx] && (entries[w_idx].regsel == rd_sel)) begin
        hit  = 1'b1;
        data = entries[w_idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : In-order register-write buffer feeding the register-file write
//            port; read forwarding enabled by defining WB_QUEUE_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_queue import wb_queue_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_queue_if.slave bus
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam int                 c_cnt_w   = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  wbq_entry_t         r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Ready depends on state only, so a full queue refuses even while draining.
  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.drain_en & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_head          <= r_head + c_ptr_one;
        r_valid[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_mem[r_tail]   <= '{regsel: bus.in_regsel, data: bus.in_data};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  assign bus.in_ready    = ~w_full;
  assign bus.write       = w_pop;
  assign bus.count       = r_count;
  assign bus.writeregsel = w_empty ? '0 : r_mem[r_head].regsel;
  assign bus.writedata   = w_empty ? '0 : r_mem[r_head].data;

`ifdef WB_QUEUE_FWD_EN
  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (r_mem),
    .valid   (r_valid),
    .head    (r_head),
    .rd_sel  (bus.read1regsel),
    .hit     (bus.fwd1_hit),
    .data    (bus.fwd1_data)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (r_mem),
    .valid   (r_valid),
    .head    (r_head),
    .rd_sel  (bus.read2regsel),
    .hit     (bus.fwd2_hit),
    .data    (bus.fwd2_data)
  );
`else
  // Without forwarding the consumer must stall whenever the queue is non-empty.
  logic w_fwd_unused;
  assign w_fwd_unused  = ^{bus.read1regsel, bus.read2regsel, r_valid};
  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Self-checking bench for wb_queue: vector table plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int c_depth = 4;

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        drain;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_wr;
    logic [2:0]  e_sel;
    logic [15:0] e_data;
    logic        e_h1;
    logic [15:0] e_d1;
    logic        e_h2;
    logic [15:0] e_d2;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic fwd_on;
  wbq_entry_t sb [$];
  vec_t       vecs [22];

  always #5 clk = ~clk;

  wb_queue_if #(.DEPTH(c_depth)) bus ();

  wb_queue #(.DEPTH(c_depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] sel, input logic [15:0] data,
                       input logic drain, input logic [2:0] r1, input logic [2:0] r2);
    bus.in_valid    = vld;
    bus.in_regsel   = sel;
    bus.in_data     = data;
    bus.drain_en    = drain;
    bus.read1regsel = r1;
    bus.read2regsel = r2;
  endtask

  function automatic void fwd_model(input logic [2:0] r, output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    if (fwd_on) begin
      foreach (sb[i]) begin
        if (sb[i].regsel == r) begin
          hit = 1'b1;
          d   = sb[i].data;
        end
      end
    end
  endfunction

  task automatic model_check(input string tag);
    wbq_entry_t  hd;
    logic        eh;
    logic [15:0] ed;
    hd = (sb.size() > 0) ? sb[0] : '0;
    chk($sformatf("%s in_ready", tag), 16'(bus.in_ready), 16'(sb.size() < c_depth));
    chk($sformatf("%s count", tag), 16'(bus.count), 16'(sb.size()));
    chk($sformatf("%s write", tag), 16'(bus.write), 16'((sb.size() > 0) && bus.drain_en));
    chk($sformatf("%s writeregsel", tag), 16'(bus.writeregsel), 16'(hd.regsel));
    chk($sformatf("%s writedata", tag), bus.writedata, hd.data);
    fwd_model(bus.read1regsel, eh, ed);
    chk($sformatf("%s fwd1_hit", tag), 16'(bus.fwd1_hit), 16'(eh));
    chk($sformatf("%s fwd1_data", tag), bus.fwd1_data, ed);
    fwd_model(bus.read2regsel, eh, ed);
    chk($sformatf("%s fwd2_hit", tag), 16'(bus.fwd2_hit), 16'(eh));
    chk($sformatf("%s fwd2_data", tag), bus.fwd2_data, ed);
  endtask

  task automatic half(input string tag);
    @(negedge clk);
    model_check(tag);
  endtask

  // Scoreboard update at the active edge, from the bench's own view of full/empty.
  task automatic advance();
    logic       do_push;
    logic       do_pop;
    wbq_entry_t e;
    @(posedge clk);
    do_push = bus.in_valid && (sb.size() < c_depth);
    do_pop  = bus.drain_en && (sb.size() > 0);
    if (do_pop) void'(sb.pop_front());
    if (do_push) begin
      e.regsel = bus.in_regsel;
      e.data   = bus.in_data;
      sb.push_back(e);
    end
    #1;
  endtask

  initial begin
`ifdef WB_QUEUE_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    // vld sel data drain r1 r2 | rdy cnt wr wsel wdata | h1 d1 h2 d2
    vecs[0]  = '{1'b1,3'd3,16'h1234,1'b1,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[1]  = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd1,1'b1,3'd3,16'h1234, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[2]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[3]  = '{1'b1,3'd1,16'h0001,1'b0,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[4]  = '{1'b1,3'd2,16'h0002,1'b0,3'd0,3'd0, 1'b1,3'd1,1'b0,3'd1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[5]  = '{1'b1,3'd3,16'h0003,1'b0,3'd0,3'd0, 1'b1,3'd2,1'b0,3'd1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[6]  = '{1'b1,3'd4,16'h0004,1'b0,3'd0,3'd0, 1'b1,3'd3,1'b0,3'd1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[7]  = '{1'b1,3'd5,16'h0005,1'b0,3'd0,3'd0, 1'b0,3'd4,1'b0,3'd1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[8]  = '{1'b1,3'd5,16'h0005,1'b1,3'd0,3'd0, 1'b0,3'd4,1'b1,3'd1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[9]  = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd3,1'b1,3'd2,16'h0002, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[10] = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd2,1'b1,3'd3,16'h0003, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[11] = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd1,1'b1,3'd4,16'h0004, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[12] = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[13] = '{1'b1,3'd5,16'hAAAA,1'b0,3'd5,3'd6, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[14] = '{1'b1,3'd5,16'hBBBB,1'b0,3'd5,3'd5, 1'b1,3'd1,1'b0,3'd5,16'hAAAA, 1'b1,16'hAAAA,1'b1,16'hAAAA};
    vecs[15] = '{1'b0,3'd0,16'h0000,1'b0,3'd5,3'd6, 1'b1,3'd2,1'b0,3'd5,16'hAAAA, 1'b1,16'hBBBB,1'b0,16'h0000};
    vecs[16] = '{1'b0,3'd0,16'h0000,1'b1,3'd5,3'd6, 1'b1,3'd2,1'b1,3'd5,16'hAAAA, 1'b1,16'hBBBB,1'b0,16'h0000};
    vecs[17] = '{1'b0,3'd0,16'h0000,1'b1,3'd5,3'd6, 1'b1,3'd1,1'b1,3'd5,16'hBBBB, 1'b1,16'hBBBB,1'b0,16'h0000};
    vecs[18] = '{1'b0,3'd0,16'h0000,1'b0,3'd5,3'd6, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[19] = '{1'b1,3'd0,16'h0F0F,1'b0,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[20] = '{1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0, 1'b1,3'd1,1'b1,3'd0,16'h0F0F, 1'b1,16'h0F0F,1'b1,16'h0F0F};
    vecs[21] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0, 1'b1,3'd0,1'b0,3'd0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};

    // Reset state, with drain requested to show write stays low when empty.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    model_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].drain, vecs[i].r1, vecs[i].r2);
      half($sformatf("sb%0d", i));
      chk($sformatf("vec%0d in_ready", i), 16'(bus.in_ready), 16'(vecs[i].e_rdy));
      chk($sformatf("vec%0d count", i), 16'(bus.count), 16'(vecs[i].e_cnt));
      chk($sformatf("vec%0d write", i), 16'(bus.write), 16'(vecs[i].e_wr));
      chk($sformatf("vec%0d writeregsel", i), 16'(bus.writeregsel), 16'(vecs[i].e_sel));
      chk($sformatf("vec%0d writedata", i), bus.writedata, vecs[i].e_data);
      chk($sformatf("vec%0d fwd1_hit", i), 16'(bus.fwd1_hit), 16'(fwd_on & vecs[i].e_h1));
      chk($sformatf("vec%0d fwd1_data", i), bus.fwd1_data, fwd_on ? vecs[i].e_d1 : 16'h0);
      chk($sformatf("vec%0d fwd2_hit", i), 16'(bus.fwd2_hit), 16'(fwd_on & vecs[i].e_h2));
      chk($sformatf("vec%0d fwd2_data", i), bus.fwd2_data, fwd_on ? vecs[i].e_d2 : 16'h0);
      advance();
    end

    // Asynchronous reset between edges with three writes pending.
    drive(1'b1, 3'd1, 16'h0101, 1'b0, 3'd0, 3'd0); half("fill0"); advance();
    drive(1'b1, 3'd2, 16'h0202, 1'b0, 3'd0, 3'd0); half("fill1"); advance();
    drive(1'b1, 3'd6, 16'h0606, 1'b0, 3'd0, 3'd0); half("fill2"); advance();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd6);
    #1;
    model_check("pre_rst");
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_check("async_rst");
    @(posedge clk);
    #1;
    model_check("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd6);
    half("post_rst");
    advance();

    // Sustained push+pop: one entry resident while the pointers wrap.
    drive(1'b1, 3'd7, 16'h0100, 1'b1, 3'd7, 3'd2);
    half("wrap_first");
    advance();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 3'(k), 16'(16'h0100 + k), 1'b1, 3'd7, 3'd2);
      half($sformatf("wrap%0d", k));
      advance();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd2);
    half("wrap_last");
    advance();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    half("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
# wb_queue

Register-write buffer sitting directly upstream of the 8x16-bit register file's single write port. Accepts register-write requests from the writeback stage through a valid/ready handshake, holds them in a small in-order FIFO, and drains at most one per cycle into the register file's `writeregsel`/`writedata`/`write` inputs whenever the write slot is granted. Optionally provides read-port forwarding so that operands whose newest value is still queued are not read stale from the register file.

## Interface
- `DEPTH`, 4: number of queued writes; power of two, 2..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  writeback presents a register write.
- `in_regsel`  in  3  destination register.
- `in_data`  in  16  write data.
- `in_ready`  out  1  queue can accept; equals `!full`, a function of state only.
- `drain_en`  in  1  register-file write slot granted this cycle.
- `writeregsel`  out  3  to rf; head entry register.
- `writedata`  out  16  to rf; head entry data.
- `write`  out  1  to rf; `!empty & drain_en`.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `read1regsel`, `read2regsel`  in  3  the register file's read selects, mirrored.
- `fwd1_hit`, `fwd2_hit`  out  1  queued write pending for that register.
- `fwd1_data`, `fwd2_data`  out  16  youngest queued data for that register.

## Operation
- Push: `in_valid & in_ready` at a rising edge writes {`in_regsel`, `in_data`} at the tail; tail pointer advances modulo DEPTH.
- Pop: `write` (`!empty & drain_en`) at a rising edge retires the head; head pointer advances modulo DEPTH.
- Strict FIFO order; two writes to the same register retire oldest first, never merged or reordered.
- `writeregsel`/`writedata` always show the head entry; when empty they hold 0 and `write` is 0 regardless of `drain_en`.
- Simultaneous push and pop when neither full nor empty: both occur, `count` unchanged.
- Empty with push: no same-cycle passthrough; the entry becomes head next cycle.
- Full: `in_ready`=0 even if a pop occurs the same cycle (no combinational ready from `drain_en`); `in_valid` while full is ignored, the producer holds.
- `count` increments on push-only, decrements on pop-only; pointers wrap silently.
- Forwarding: for each read select, scan valid entries; hit if any `regsel` matches; data from the youngest matching entry (closest to tail). The entry being popped this cycle still counts as a hit (the rf updates only at the edge).
- Register 0 is ordinary; no special-casing.

## Timing
- Reset (`rst`=0, asynchronous): head=tail=0, `count`=0, `in_ready`=1, `write`=0, `writeregsel`=0, `writedata`=0, `fwd*_hit`=0, `fwd*_data`=0. Queued entries are discarded; reset mid-operation loses pending writes by design.
- Push-to-rf latency: minimum 1 cycle (push at edge N, `write` asserted in cycle N+1 if `drain_en`).
- Throughput: one push and one pop per cycle sustained.
- Forwarding outputs are combinational from `read*regsel` and queue state; no added cycles.

## Configuration
- `WB_QUEUE_FWD_EN` defined: match logic and `fwd*` outputs implemented as above.
- Undefined: no match logic; `fwd*_hit` and `fwd*_data` tied to 0; the pipeline must stall on any non-empty queue instead (documented consumer obligation).

## Structure
- Shared package: `WORD_W`=16, `REG_SEL_W`=3, `NUM_REGS`=8, typedef `wbq_entry_t` {regsel, data}.
- One sub-module: `wbq_match` — given entry array, valid mask, head pointer, and one read select, returns hit and youngest-match data; instantiated twice, only under `WB_QUEUE_FWD_EN`.

## Test plan
- Reset then push {r3, 0x1234} with `drain_en`=1 -> next cycle `write`=1, `writeregsel`=3, `writedata`=0x1234; following cycle `count`=0, `write`=0.
- `drain_en`=0, push r1=0x0001, r2=0x0002, r3=0x0003, r4=0x0004 -> `count`=4, `in_ready`=0; fifth `in_valid` ignored; enable drain -> rf sees r1..r4 in order over 4 cycles.
- Full queue, `in_valid`=1 and `drain_en`=1 same cycle -> one pop, no push, `count`=3, `in_ready`=1 next cycle.
- Push r5=0xAAAA then r5=0xBBBB, `drain_en`=0, `read1regsel`=5, `read2regsel`=6 -> `fwd1_hit`=1, `fwd1_data`=0xBBBB, `fwd2_hit`=0; drain -> rf writes 0xAAAA then 0xBBBB.
- Assert `rst`=0 mid-cycle with 3 entries queued -> outputs go to reset values immediately without a clock edge; after release, `count`=0, no stale write.
- Continuous push and drain for 20 cycles with incrementing data -> pointers wrap, `count` constant at 1, data order preserved.
